// File: rtl/ext_mem_responder.sv
// Main-memory responder: tagged read/write requests, masked write beats,
// fixed-latency tagged read bursts from a word-addressed backing store.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   mem_req_valid/ready        request handshake (ready only in IDLE)
//   mem_req_rw                 1 = write, 0 = read
//   mem_req_addr, mem_req_tag  base word address, tag echoed on reads
//   mem_req_data_valid/ready   write beat handshake (ready only in WDATA)
//   mem_req_data_bits/mask     write beat data, per-byte enables
//   mem_resp_valid/data/tag    read beats, zero when not valid
module ext_mem_responder #(
    parameter int ADDR_BITS   = 28,
    parameter int DATA_BITS   = 128,
    parameter int TAG_BITS    = 5,
    parameter int DATA_CYCLES = 4,
    parameter int DEPTH_LOG2  = 12,
    parameter int LATENCY     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic                   mem_req_rw,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic [TAG_BITS-1:0]    mem_req_tag,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                   mem_resp_valid,
    output logic [DATA_BITS-1:0]   mem_resp_data,
    output logic [TAG_BITS-1:0]    mem_resp_tag
);

    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int B_W = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
    localparam int L_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [B_W-1:0] B_LAST = B_W'(DATA_CYCLES - 1);
    // RWAIT lasts LATENCY-1 cycles; the counter starts at 0.
    localparam logic [L_W-1:0] L_LAST =
        L_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        RWAIT,
        RRESP
    } state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] base;
    logic [B_W-1:0]        beat;
    logic [L_W-1:0]        lat_cnt;
    logic [TAG_BITS-1:0]   tag_q;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  req_fire;
    logic                  data_fire;

    logic [DATA_BITS-1:0]  mem [DEPTH];

    // Word index wraps naturally at the store depth.
    assign idx = base + DEPTH_LOG2'(beat);

    // Handshake outputs are state decodes; reset forces them low at once
    // so an aborted transaction is visible the moment reset asserts.
    assign mem_req_ready      = ~reset & (state == IDLE);
    assign mem_req_data_ready = ~reset & (state == WDATA);
    assign mem_resp_valid     = ~reset & (state == RRESP);
    assign mem_resp_data      = mem_resp_valid ? mem[idx] : '0;
    assign mem_resp_tag       = mem_resp_valid ? tag_q : '0;

    assign req_fire  = mem_req_valid & mem_req_ready;
    assign data_fire = mem_req_data_valid & mem_req_data_ready;

    generate
        if (ADDR_BITS > DEPTH_LOG2) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            base    <= '0;
            beat    <= '0;
            lat_cnt <= '0;
            tag_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_fire) begin
                        base    <= mem_req_addr[DEPTH_LOG2-1:0];
                        tag_q   <= mem_req_tag;
                        beat    <= '0;
                        lat_cnt <= '0;
                        if (mem_req_rw) begin
                            state <= WDATA;
                        end else if (LATENCY > 1) begin
                            state <= RWAIT;
                        end else begin
                            state <= RRESP;
                        end
                    end
                end
                WDATA: begin
                    if (data_fire) begin
                        beat <= beat + B_W'(1);
                        if (beat == B_LAST) begin
                            state <= IDLE;
                        end
                    end
                end
                RWAIT: begin
                    if (lat_cnt == L_LAST) begin
                        state <= RRESP;
                    end else begin
                        lat_cnt <= lat_cnt + L_W'(1);
                    end
                end
                RRESP: begin
                    beat <= beat + B_W'(1);
                    if (beat == B_LAST) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Backing store is never cleared; only enabled bytes are written.
    always_ff @(posedge clk) begin
        if (data_fire) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (mem_req_data_mask[i]) begin
                    mem[idx][i*8 +: 8] <= mem_req_data_bits[i*8 +: 8];
                end
            end
        end
    end

endmodule
